// File: rtl/toggle_sync_pkg.sv
// Shared types for the toggle-synchronizer CDC handshake (transmit and receive sides).
package toggle_sync_pkg;

    typedef enum logic {
        TX_IDLE     = 1'b0,
        TX_WAIT_ACK = 1'b1
    } tsync_tx_state_e;

    // Counter width for a timeout limit; a disabled check still needs a legal 1-bit vector.
    function automatic int unsigned tsync_cnt_w(input int unsigned timeout_cyc);
        return (timeout_cyc == 0) ? 1 : $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/sync_dff.sv
// Two-flop synchronizer bringing an asynchronous signal into the clk domain.
module sync_dff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/toggle_sync_tx.sv
// Source-domain side of a toggle-synchronizer handshake: captures one word, flips req_tgl,
// and waits for the destination to echo the toggle on the asynchronous ack_tgl.
module toggle_sync_tx
    import toggle_sync_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic [WIDTH-1:0] o_xfer_data,
    output logic             o_req_tgl,
    input  logic             i_ack_tgl,
    output logic             o_xfer_done,
    output logic             o_timeout_err,
    input  logic             i_err_clr
);

    localparam int unsigned     CntW   = tsync_cnt_w(TIMEOUT_CYC);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);
    localparam logic [CntW-1:0] CntSet = CntW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    tsync_tx_state_e  r_state;
    tsync_tx_state_e  w_state_d;
    logic             r_req_tgl;
    logic             w_req_tgl_d;
    logic [WIDTH-1:0] r_xfer_data;
    logic [WIDTH-1:0] w_xfer_data_d;
    logic [CntW-1:0]  r_cnt;
    logic [CntW-1:0]  w_cnt_d;
    logic             r_in_ready;
    logic             w_in_ready_d;
    logic             r_xfer_done;
    logic             w_xfer_done_d;
    logic             r_timeout_err;
    logic             w_timeout_err_d;
    logic             w_timeout_set;

    logic             w_ack_s;
    logic             w_match;
    logic             w_accept;

    sync_dff #(
        .WIDTH (1)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_ack_tgl),
        .o_q   (w_ack_s)
    );

    assign w_match  = (w_ack_s == r_req_tgl);
    assign w_accept = (r_state == TX_IDLE) && i_in_valid && r_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            TX_IDLE:     if (w_accept) w_state_d = TX_WAIT_ACK;
            TX_WAIT_ACK: if (w_match)  w_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        w_req_tgl_d   = r_req_tgl;
        w_xfer_data_d = r_xfer_data;
        w_cnt_d       = r_cnt;
        w_xfer_done_d = 1'b0;
        w_timeout_set = 1'b0;

        if (w_accept) begin
            w_req_tgl_d   = ~r_req_tgl;
            w_xfer_data_d = i_in_data;
            w_cnt_d       = '0;
        end

        if (r_state == TX_WAIT_ACK) begin
            w_xfer_done_d = w_match;
            if (TIMEOUT_CYC != 0) begin
                if (r_cnt != CntMax) begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
                // Counter saturates, so this fires once per outstanding word.
                w_timeout_set = (r_cnt == CntSet);
            end
        end

        // Ready only once the synchronized ack agrees with the request we will hold.
        w_in_ready_d    = (w_state_d == TX_IDLE) && (w_ack_s == w_req_tgl_d);
        w_timeout_err_d = w_timeout_set | (r_timeout_err & ~i_err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_tgl     <= 1'b0;
            r_xfer_data   <= '0;
            r_cnt         <= '0;
            r_in_ready    <= 1'b0;
            r_xfer_done   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_req_tgl     <= w_req_tgl_d;
            r_xfer_data   <= w_xfer_data_d;
            r_cnt         <= w_cnt_d;
            r_in_ready    <= w_in_ready_d;
            r_xfer_done   <= w_xfer_done_d;
            r_timeout_err <= w_timeout_err_d;
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_xfer_data   = r_xfer_data;
    assign o_req_tgl     = r_req_tgl;
    assign o_xfer_done   = r_xfer_done;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_toggle_sync_tx.sv
// Self-checking bench for toggle_sync_tx with a loopback destination on an unrelated clock.
module tb_toggle_sync_tx;

    logic       clk;
    logic       dclk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] xfer_data;
    logic       req_tgl;
    logic       ack_tgl;
    logic       xfer_done;
    logic       timeout_err;
    logic       err_clr;

    logic       loop_en;
    logic       man_ack;
    logic       lb_ack;
    logic       rx_m;
    logic       rx_s;
    logic       rx_prev;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       exp_req;
    int         n_checks;
    int         n_fail;

    toggle_sync_tx #(
        .WIDTH       (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_data     (in_data),
        .o_xfer_data   (xfer_data),
        .o_req_tgl     (req_tgl),
        .i_ack_tgl     (ack_tgl),
        .o_xfer_done   (xfer_done),
        .o_timeout_err (timeout_err),
        .i_err_clr     (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        dclk = 1'b0;
        forever #7 dclk = ~dclk;
    end

    assign ack_tgl = loop_en ? lb_ack : man_ack;

    // Destination model: sync req_tgl, capture the word on a toggle, echo the toggle back.
    always @(posedge dclk) begin
        if (!loop_en) begin
            rx_m    <= req_tgl;
            rx_s    <= req_tgl;
            rx_prev <= req_tgl;
            lb_ack  <= man_ack;
        end else begin
            rx_m <= req_tgl;
            rx_s <= rx_m;
            if (rx_s != rx_prev) begin
                rx_prev <= rx_s;
                lb_ack  <= rx_s;
                rx_q.push_back(xfer_data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        man_ack = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
        n_checks++;
        if (req_tgl !== 1'b0) begin n_fail++; $display("FAIL reset_req_tgl: got %b, expected 0", req_tgl); end
        n_checks++;
        if (xfer_data !== 8'h00) begin n_fail++; $display("FAIL reset_xfer_data: got %h, expected 00", xfer_data); end
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b, expected 0", timeout_err); end
        n_checks++;
        if (xfer_done !== 1'b0) begin n_fail++; $display("FAIL reset_xfer_done: got %b, expected 0", xfer_done); end
        rst_n = 1'b1;
        exp_req = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b, expected 1", in_ready); end
    endtask

    task automatic test_single();
        logic [7:0] exp;
        in_data = 8'hA5;
        in_valid = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        exp_req = ~exp_req;
        in_valid = 1'b0;
        n_checks++;
        if (req_tgl !== exp_req) begin n_fail++; $display("FAIL single_req: got %b, expected %b", req_tgl, exp_req); end
        n_checks++;
        if (xfer_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h, expected a5", xfer_data); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b, expected 0", in_ready); end
        tick(); tick();
        n_checks++;
        if (in_ready !== 1'b0 || xfer_done !== 1'b0) begin
            n_fail++; $display("FAIL single_wait: ready/done got %b%b, expected 00", in_ready, xfer_done);
        end
        man_ack = exp_req;
        tick();
        n_checks++;
        if (xfer_done !== 1'b0) begin n_fail++; $display("FAIL single_done_t0: got %b, expected 0", xfer_done); end
        tick();
        n_checks++;
        if (xfer_done !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL single_done_t1: done/ready got %b%b, expected 00", xfer_done, in_ready);
        end
        tick();
        n_checks++;
        if (xfer_done !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_done_t2: done/ready got %b%b, expected 11", xfer_done, in_ready);
        end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++;
        if (xfer_data !== exp) begin n_fail++; $display("FAIL single_sb: got %h, expected %h", xfer_data, exp); end
        tick();
        n_checks++;
        if (xfer_done !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b, expected 0", xfer_done); end
    endtask

    task automatic test_back_to_back();
        int         idx;
        int         flips;
        int         dones;
        logic       acc;
        logic       prev_req;
        logic [7:0] exp;
        logic [7:0] got;
        exp_q.delete();
        rx_q.delete();
        idx = 0;
        flips = 0;
        dones = 0;
        loop_en = 1'b1;
        in_data = 8'h01;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 400 && dones < 4; cyc++) begin
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back(in_data);
            prev_req = req_tgl;
            tick();
            if (acc) begin
                exp_req = ~exp_req;
                idx++;
                if (idx < 4) in_data = 8'(idx + 1);
                else in_valid = 1'b0;
            end
            if (req_tgl !== prev_req) flips++;
            if (xfer_done === 1'b1) begin
                dones++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                got = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
                n_checks++;
                if (got !== exp) begin n_fail++; $display("FAIL b2b_word%0d: got %h, expected %h", dones, got, exp); end
            end
        end
        for (int i = 0; i < 20; i++) begin
            prev_req = req_tgl;
            tick();
            if (req_tgl !== prev_req) flips++;
            if (xfer_done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 4) begin n_fail++; $display("FAIL b2b_done_count: got %0d, expected 4", dones); end
        n_checks++;
        if (flips != 4) begin n_fail++; $display("FAIL b2b_flip_count: got %0d, expected 4", flips); end
        n_checks++;
        if (rx_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_leftover: rx %0d exp %0d, expected 0 0", rx_q.size(), exp_q.size());
        end
        man_ack = exp_req;
        loop_en = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        in_data = 8'h3C;
        in_valid = 1'b1;
        tick();
        exp_req = ~exp_req;
        n_checks++;
        if (req_tgl !== exp_req || xfer_data !== 8'h3C) begin
            n_fail++; $display("FAIL hold_accept: req/data got %b/%h, expected %b/3c", req_tgl, xfer_data, exp_req);
        end
        for (int i = 0; i < 6; i++) begin
            in_data = 8'h3C ^ 8'(i + 1);
            tick();
            n_checks++;
            if (xfer_data !== 8'h3C || req_tgl !== exp_req || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: data/req/ready got %h/%b/%b, expected 3c/%b/0",
                         i, xfer_data, req_tgl, in_ready, exp_req);
            end
        end
        in_valid = 1'b0;
        man_ack = exp_req;
        tick(); tick(); tick();
        n_checks++;
        if (xfer_done !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_done: done/ready got %b%b, expected 11", xfer_done, in_ready);
        end
        tick();
    endtask

    task automatic test_timeout();
        err_clr = 1'b0;
        in_data = 8'h5A;
        in_valid = 1'b1;
        tick();
        exp_req = ~exp_req;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b, expected 0", in_ready); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) begin
                n_checks++;
                if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b, expected 0", timeout_err); end
            end
            if (k == 16) begin
                n_checks++;
                if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_set: got %b, expected 1", timeout_err); end
            end
        end
        man_ack = exp_req;
        tick(); tick(); tick();
        n_checks++;
        if (xfer_done !== 1'b1) begin n_fail++; $display("FAIL to_late_ack: got %b, expected 1", xfer_done); end
        tick(); tick();
        n_checks++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b, expected 1", timeout_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b, expected 0", timeout_err); end
        in_data = 8'hC3;
        in_valid = 1'b1;
        tick();
        exp_req = ~exp_req;
        in_valid = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early2: got %b, expected 0", timeout_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_set_wins: got %b, expected 1", timeout_err); end
        man_ack = exp_req;
        tick(); tick(); tick();
        n_checks++;
        if (xfer_done !== 1'b1) begin n_fail++; $display("FAIL to_done2: got %b, expected 1", xfer_done); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear2: got %b, expected 0", timeout_err); end
    endtask

    task automatic test_reset_mid();
        in_data = 8'h77;
        in_valid = 1'b1;
        tick();
        exp_req = ~exp_req;
        in_valid = 1'b0;
        n_checks++;
        if (req_tgl !== exp_req) begin n_fail++; $display("FAIL mid_req: got %b, expected %b", req_tgl, exp_req); end
        man_ack = 1'b1;
        rst_n = 1'b0;
        tick(); tick(); tick();
        exp_req = 1'b0;
        n_checks++;
        if (req_tgl !== 1'b0 || in_ready !== 1'b0 || xfer_data !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: req/ready/data got %b/%b/%h, expected 0/0/00", req_tgl, in_ready, xfer_data);
        end
        rst_n = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_hold%0d: got %b, expected 0", i, in_ready); end
            tick();
        end
        man_ack = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_t0: got %b, expected 0", in_ready); end
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_t1: got %b, expected 0", in_ready); end
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || xfer_done !== 1'b0) begin
            n_fail++; $display("FAIL mid_t2: ready/done got %b%b, expected 10", in_ready, xfer_done);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        err_clr = 1'b0;
        man_ack = 1'b0;
        loop_en = 1'b0;
        exp_req = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
